// File: rtl/epochtv1_cpu_arb_pkg.sv
// epochtv1_cpu_arb_pkg: shared types for the Epoch TV-1 CPU/video-memory arbiter.
//   mem_sel_t   : memory target (VRAM A, VRAM B, BGM, OAM)
//   arb_state_t : arbiter FSM states
//   req_t       : one captured CPU access
//   decode_addr : maps a 13-bit CPU address onto target/word address
package epochtv1_cpu_arb_pkg;

   typedef enum logic [1:0] {
      SEL_VRAMA = 2'd0,
      SEL_VRAMB = 2'd1,
      SEL_BGM   = 2'd2,
      SEL_OAM   = 2'd3
   } mem_sel_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PEND,
      ST_ISSUE,
      ST_RDWAIT
   } arb_state_t;

   localparam logic [3:0] BGM_PAGE      = 4'b1000;
   localparam logic [3:0] OAM_PAGE      = 4'b1001;
   localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

   typedef struct packed {
      logic        we;
      mem_sel_t    sel;
      logic [11:0] a;
      logic [7:0]  d;
      logic        mapped;   // 0: accepted but never reaches a memory
      logic        valid;
   } req_t;

   localparam req_t REQ_NONE = '0;

   function automatic req_t decode_addr(input logic [12:0] addr,
                                        input logic        we,
                                        input logic [7:0]  d);
      req_t r;
      r        = REQ_NONE;
      r.we     = we;
      r.d      = d;
      r.valid  = 1'b1;
      r.mapped = 1'b1;
      if (!addr[12]) begin
         // VRAM A/B interleave on the address LSB
         r.sel = addr[0] ? SEL_VRAMB : SEL_VRAMA;
         r.a   = {1'b0, addr[11:1]};
      end else if (addr[12:9] == BGM_PAGE) begin
         r.sel = SEL_BGM;
         r.a   = {3'b000, addr[8:0]};
      end else if (addr[12:9] == OAM_PAGE) begin
         r.sel = SEL_OAM;
         r.a   = {3'b000, addr[8:0]};
      end else begin
         r.mapped = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/epochtv1_cpu_arb_if.sv
// epochtv1_cpu_arb_if: CPU bus, renderer handshake and memory port of the arbiter.
//   CPU    : A, DB_I, DB_O, DB_OE, RDB, WRB, CSB
//   Slots  : CE, REN_BUSY, REN_STALL
//   Memory : MEM_REQ, MEM_SEL, MEM_A, MEM_WE, MEM_D, MEM_Q
//   Debug  : DBG_OVF (sticky request-queue overflow)
// slave = arbiter side, master = system/bench side.
interface epochtv1_cpu_arb_if;
   logic        CE;
   logic [12:0] A;
   logic [7:0]  DB_I;
   logic [7:0]  DB_O;
   logic        DB_OE;
   logic        RDB;
   logic        WRB;
   logic        CSB;
   logic        REN_BUSY;
   logic        REN_STALL;
   logic        MEM_REQ;
   logic [1:0]  MEM_SEL;
   logic [11:0] MEM_A;
   logic        MEM_WE;
   logic [7:0]  MEM_D;
   logic [7:0]  MEM_Q;
   logic        DBG_OVF;

   modport slave (
      input  CE, A, DB_I, RDB, WRB, CSB, REN_BUSY, MEM_Q,
      output DB_O, DB_OE, REN_STALL, MEM_REQ, MEM_SEL, MEM_A, MEM_WE, MEM_D, DBG_OVF
   );

   modport master (
      output CE, A, DB_I, RDB, WRB, CSB, REN_BUSY, MEM_Q,
      input  DB_O, DB_OE, REN_STALL, MEM_REQ, MEM_SEL, MEM_A, MEM_WE, MEM_D, DBG_OVF
   );
endinterface

// File: rtl/epochtv1_cpu_arb_strobe_cap.sv
// epochtv1_strobe_cap: CPU strobe edge detectors and the two-entry request queue.
//   clk, resb : clock, synchronous active-low reset
//   a, wdata  : CPU address / write data, sampled at capture
//   rdb, wrb, csb : CPU strobes (active low)
//   pop       : head entry consumed by the arbiter this cycle
//   cur       : head of queue (oldest pending access)
//   ovf       : sticky, a capture arrived with both entries full
module epochtv1_strobe_cap
   import epochtv1_cpu_arb_pkg::*;
(
   input  logic        clk,
   input  logic        resb,
   input  logic [12:0] a,
   input  logic [7:0]  wdata,
   input  logic        rdb,
   input  logic        wrb,
   input  logic        csb,
   input  logic        pop,
   output req_t        cur,
   output logic        ovf
);

   logic rdb_q;
   logic wrb_q;
   logic rd_cap;
   logic wr_cap;
   logic cap;
   req_t cap_req;
   req_t nxt;

   // Reads capture on RDB falling; writes are posted on WRB rising.
   assign rd_cap  = rdb_q & ~rdb & ~csb;
   assign wr_cap  = ~wrb_q & wrb & ~csb;
   assign cap     = rd_cap | wr_cap;
   assign cap_req = decode_addr(a, wr_cap, wdata);

   always_ff @(posedge clk) begin
      if (!resb) begin
         rdb_q <= 1'b1;
         wrb_q <= 1'b1;
         cur   <= REQ_NONE;
         nxt   <= REQ_NONE;
         ovf   <= 1'b0;
      end else begin
         rdb_q <= rdb;
         wrb_q <= wrb;
         if (pop) begin
            // A same-cycle capture lands behind whatever is still queued.
            if (nxt.valid) begin
               cur <= nxt;
               nxt <= cap ? cap_req : REQ_NONE;
            end else begin
               cur <= cap ? cap_req : REQ_NONE;
               nxt <= REQ_NONE;
            end
         end else if (cap) begin
            if (!cur.valid) begin
               cur <= cap_req;
            end else if (!nxt.valid) begin
               nxt <= cap_req;
            end else begin
               ovf <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/epochtv1_cpu_arb.sv
// epochtv1_cpu_arb: shares the TV-1 video memories between CPU and renderer.
//   CLK  : system clock
//   RESB : synchronous active-low reset
//   bus  : CPU strobes/data, CE slot and renderer handshake, memory port
// Parameters: MAX_WAIT busy slots tolerated before stealing; STEAL_EN enables stealing.
module epochtv1_cpu_arb
   import epochtv1_cpu_arb_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 2,
   parameter bit          STEAL_EN = 1'b1
) (
   input logic               CLK,
   input logic               RESB,
   epochtv1_cpu_arb_if.slave bus
);

   arb_state_t state;
   req_t       cur;
   logic       ovf;
   logic       pop;
   logic       steal;
   logic       slot_ok;
   logic [1:0] wait_cnt;

   epochtv1_strobe_cap u_cap (
      .clk   (CLK),
      .resb  (RESB),
      .a     (bus.A),
      .wdata (bus.DB_I),
      .rdb   (bus.RDB),
      .wrb   (bus.WRB),
      .csb   (bus.CSB),
      .pop   (pop),
      .cur   (cur),
      .ovf   (ovf)
   );

   assign steal   = STEAL_EN && (32'(wait_cnt) == MAX_WAIT);
   assign slot_ok = bus.CE && (!bus.REN_BUSY || steal);
   // Unmapped accesses leave the queue without waiting for a slot.
   assign pop     = (state == ST_PEND) && cur.valid && (!cur.mapped || slot_ok);

   assign bus.DB_OE   = ~bus.CSB & ~bus.RDB;
   assign bus.DBG_OVF = ovf;

   always_ff @(posedge CLK) begin
      if (!RESB) begin
         state         <= ST_IDLE;
         wait_cnt      <= '0;
         bus.DB_O      <= '0;
         bus.MEM_REQ   <= 1'b0;
         bus.MEM_WE    <= 1'b0;
         bus.REN_STALL <= 1'b0;
         bus.MEM_SEL   <= '0;
         bus.MEM_A     <= '0;
         bus.MEM_D     <= '0;
      end else begin
         bus.MEM_REQ   <= 1'b0;
         bus.REN_STALL <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cur.valid) state <= ST_PEND;
            end
            ST_PEND: begin
               if (!cur.mapped) begin
                  if (!cur.we) bus.DB_O <= UNMAPPED_DATA;
                  state <= ST_IDLE;
               end else if (slot_ok) begin
                  bus.MEM_REQ   <= 1'b1;
                  bus.REN_STALL <= bus.REN_BUSY;   // only busy when stealing
                  bus.MEM_WE    <= cur.we;
                  bus.MEM_SEL   <= cur.sel;
                  bus.MEM_A     <= cur.a;
                  bus.MEM_D     <= cur.d;
                  wait_cnt      <= '0;
                  state         <= ST_ISSUE;
               end else if (bus.CE && (wait_cnt != 2'b11)) begin
                  wait_cnt <= wait_cnt + 2'd1;
               end
            end
            ST_ISSUE: begin
               if (!bus.MEM_WE)    state <= ST_RDWAIT;
               else if (cur.valid) state <= ST_PEND;
               else                state <= ST_IDLE;
            end
            ST_RDWAIT: begin
               if (bus.CE) begin
                  bus.DB_O <= bus.MEM_Q;
                  state    <= cur.valid ? ST_PEND : ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_epochtv1_cpu_arb.sv
`timescale 1ns/1ps
module tb_epochtv1_cpu_arb;

   logic CLK  = 1'b0;
   logic RESB = 1'b0;

   epochtv1_cpu_arb_if bus0();
   epochtv1_cpu_arb_if bus1();

   epochtv1_cpu_arb #(.MAX_WAIT(2), .STEAL_EN(1'b1)) dut0 (.CLK(CLK), .RESB(RESB), .bus(bus0));
   epochtv1_cpu_arb #(.MAX_WAIT(2), .STEAL_EN(1'b0)) dut1 (.CLK(CLK), .RESB(RESB), .bus(bus1));

   always #5 CLK = ~CLK;

   // Environment memories (written by the arbiter) and reference image (written by the model).
   logic [7:0]  env_mem [4][4096];
   logic [7:0]  ref_mem [4][4096];
   logic [22:0] exp_iss [$];

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;
   int unsigned ce_cnt = 0;
   int unsigned req0 = 0, stall0 = 0, req1 = 0, stall1 = 0;
   int unsigned last_req_ce0 = 0;
   logic        busy_at_ce = 1'b0;
   bit          busy_mode = 1'b0;
   logic        busy_val = 1'b0;

   assign bus1.CE       = bus0.CE;
   assign bus1.A        = bus0.A;
   assign bus1.DB_I     = bus0.DB_I;
   assign bus1.RDB      = bus0.RDB;
   assign bus1.WRB      = bus0.WRB;
   assign bus1.CSB      = bus0.CSB;
   assign bus1.REN_BUSY = bus0.REN_BUSY;
   assign bus0.MEM_Q    = env_mem[bus0.MEM_SEL][bus0.MEM_A];
   assign bus1.MEM_Q    = env_mem[bus1.MEM_SEL][bus1.MEM_A];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference address map, from the address ranges.
   function automatic bit ref_map(input int unsigned addr, output logic [1:0] sel, output logic [11:0] wa);
      sel = 2'd0; wa = 12'd0;
      if (addr < 'h1000) begin sel = 2'(addr % 2); wa = 12'(addr / 2); return 1'b1; end
      if (addr >= 'h1000 && addr < 'h1200) begin sel = 2'd2; wa = 12'(addr - 'h1000); return 1'b1; end
      if (addr >= 'h1200 && addr < 'h1400) begin sel = 2'd3; wa = 12'(addr - 'h1200); return 1'b1; end
      return 1'b0;
   endfunction

   initial begin
      bus0.CE = 1'b0;
      forever begin
         @(negedge CLK);
         bus0.CE = ~bus0.CE;
      end
   end

   initial begin
      bus0.REN_BUSY = 1'b0;
      forever begin
         @(negedge CLK);
         bus0.REN_BUSY = busy_mode ? 1'($urandom_range(0, 1)) : busy_val;
      end
   end

   always @(posedge CLK) begin
      if (bus0.CE) begin
         ce_cnt++;
         busy_at_ce = bus0.REN_BUSY;
      end
      if (RESB && bus0.MEM_REQ && bus0.MEM_WE) env_mem[bus0.MEM_SEL][bus0.MEM_A] = bus0.MEM_D;
   end

   always @(negedge CLK) begin
      logic [22:0] got, e;
      if (RESB) begin
         if (bus0.MEM_REQ || bus0.REN_STALL)
            chk("stall_slot", bus0.REN_STALL, bus0.MEM_REQ & busy_at_ce);
         if (bus0.MEM_REQ) begin
            req0++;
            last_req_ce0 = ce_cnt;
            if (bus0.REN_STALL) stall0++;
            if (exp_iss.size() == 0) begin
               chk("unexpected_req", 32'(exp_iss.size()), 1);
            end else begin
               e   = exp_iss.pop_front();
               got = {bus0.MEM_WE, bus0.MEM_SEL, bus0.MEM_A, (bus0.MEM_WE ? bus0.MEM_D : 8'h00)};
               chk("issue", got, e);
            end
         end
         if (bus1.MEM_REQ) req1++;
         if (bus1.REN_STALL) stall1++;
      end
   end

   task automatic cpu_write(input int unsigned addr, input logic [7:0] data, input bit fast,
                            input bit lost, output int unsigned st);
      logic [1:0] sel; logic [11:0] wa; bit m;
      m = ref_map(addr, sel, wa);
      @(negedge CLK);
      bus0.A = 13'(addr); bus0.DB_I = data; bus0.CSB = 1'b0; bus0.WRB = 1'b0;
      @(negedge CLK);
      bus0.WRB = 1'b1;
      st = ce_cnt;
      if (m && !lost) begin
         ref_mem[sel][wa] = data;
         exp_iss.push_back({1'b1, sel, wa, data});
      end
      if (!fast) begin
         @(negedge CLK);
         bus0.CSB = 1'b1;
      end
   endtask

   task automatic cpu_read(input int unsigned addr, output int unsigned st);
      logic [1:0] sel; logic [11:0] wa; bit m; logic [7:0] exp;
      m = ref_map(addr, sel, wa);
      exp = m ? ref_mem[sel][wa] : 8'hFF;
      @(negedge CLK);
      bus0.A = 13'(addr); bus0.CSB = 1'b0;
      @(negedge CLK);
      bus0.RDB = 1'b0;
      st = ce_cnt;
      if (m) exp_iss.push_back({1'b0, sel, wa, 8'h00});
      repeat (26) @(negedge CLK);
      chk("rd_data", bus0.DB_O, exp);
      chk("rd_oe", bus0.DB_OE, 1);
      bus0.RDB = 1'b1; bus0.CSB = 1'b1;
      @(negedge CLK);
      chk("rd_oe_off", bus0.DB_OE, 0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_db_o", bus0.DB_O, 0);
      chk("rst_req", bus0.MEM_REQ, 0);
      chk("rst_we", bus0.MEM_WE, 0);
      chk("rst_stall", bus0.REN_STALL, 0);
      chk("rst_sel", bus0.MEM_SEL, 0);
      chk("rst_a", bus0.MEM_A, 0);
      chk("rst_d", bus0.MEM_D, 0);
      chk("rst_ovf", bus0.DBG_OVF, 0);
   endtask

   initial begin
      int unsigned st, r0, r1, s0, addr;
      bus0.A = '0; bus0.DB_I = '0; bus0.RDB = 1'b1; bus0.WRB = 1'b1; bus0.CSB = 1'b1;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4096; j++) begin
            env_mem[i][j] = 8'h00;
            ref_mem[i][j] = 8'h00;
         end
      env_mem[3][0] = 8'h5A; ref_mem[3][0] = 8'h5A;
      env_mem[2][0] = 8'h3C; ref_mem[2][0] = 8'h3C;

      repeat (3) @(negedge CLK);
      check_reset_outputs();
      RESB = 1'b1;
      repeat (2) @(negedge CLK);

      // OAM read, renderer idle
      r0 = req0; s0 = stall0;
      cpu_read('h1200, st);
      chk("oam_rd_req", req0 - r0, 1);
      chk("oam_rd_lat", 32'(last_req_ce0 - st <= 2), 1);
      chk("oam_rd_nostall", stall0 - s0, 0);

      // VRAM B posted write
      r0 = req0;
      cpu_write('h0003, 8'hC3, 1'b0, 1'b0, st);
      repeat (6) @(negedge CLK);
      chk("vram_wr_req", req0 - r0, 1);
      chk("vram_wr_lat", 32'(last_req_ce0 - st <= 2), 1);
      chk("vram_wr_mem", env_mem[1][1], 8'hC3);

      // Renderer hogs every slot: steal vs. no-steal
      busy_val = 1'b1;
      repeat (2) @(negedge CLK);
      r0 = req0; r1 = req1; s0 = stall0;
      cpu_read('h1000, st);
      chk("steal_lat", 32'((last_req_ce0 - st >= 3) && (last_req_ce0 - st <= 4)), 1);
      chk("steal_once", stall0 - s0, 1);
      chk("nosteal_blocked", req1 - r1, 0);
      busy_val = 1'b0;
      repeat (8) @(negedge CLK);
      chk("nosteal_issued", req1 - r1, 1);
      chk("nosteal_nostall", stall1, 0);

      // Write then immediate read of the same OAM byte
      cpu_write('h1201, 8'h96, 1'b0, 1'b0, st);
      cpu_read('h1201, st);

      // Reset while a write is pending
      busy_val = 1'b1;
      cpu_write('h0005, 8'hE7, 1'b0, 1'b1, st);
      @(negedge CLK);
      RESB = 1'b0;
      @(negedge CLK);
      check_reset_outputs();
      exp_iss.delete();
      RESB = 1'b1;
      busy_val = 1'b0;
      r0 = req0;
      repeat (12) @(negedge CLK);
      chk("abort_no_req", req0 - r0, 0);
      chk("abort_mem", env_mem[1][2], 8'h00);

      // Unmapped read
      r0 = req0;
      cpu_read('h1E00, st);
      chk("unmapped_no_req", req0 - r0, 0);

      // Queue overflow: third back-to-back capture is dropped
      busy_val = 1'b1;
      cpu_write('h1210, 8'h11, 1'b1, 1'b0, st);
      cpu_write('h1211, 8'h22, 1'b1, 1'b0, st);
      cpu_write('h1212, 8'h33, 1'b0, 1'b1, st);
      chk("ovf_steal", bus0.DBG_OVF, 1);
      chk("ovf_nosteal", bus1.DBG_OVF, 1);
      busy_val = 1'b0;
      repeat (20) @(negedge CLK);
      chk("ovf_drain", 32'(exp_iss.size()), 0);
      chk("ovf_mem", env_mem[3]['h12], 8'h00);
      RESB = 1'b0;
      @(negedge CLK);
      chk("ovf_cleared", bus0.DBG_OVF, 0);
      exp_iss.delete();
      RESB = 1'b1;
      repeat (2) @(negedge CLK);

      // Random traffic against the reference model
      busy_mode = 1'b1;
      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 3))
            0:       addr = $urandom_range(0, 15);
            1:       addr = 'h1000 + $urandom_range(0, 7);
            2:       addr = 'h1200 + $urandom_range(0, 7);
            default: addr = 'h1400 + $urandom_range(0, 'hBFF);
         endcase
         if ($urandom_range(0, 1) == 1) begin
            cpu_write(addr, 8'($urandom), 1'b0, 1'b0, st);
            repeat (8) @(negedge CLK);
         end else begin
            cpu_read(addr, st);
         end
      end
      busy_mode = 1'b0;
      repeat (20) @(negedge CLK);
      chk("final_drain", 32'(exp_iss.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
